issue_scoreboard: RTL
=====================

# issue_scoreboard

Issue-stage hazard scheduler between decode and execute of the chahan CPU pipeline. Tracks in-flight writes to the 32 GPRs and 32 FPRs using per-register countdowns taken from decode's `wait_time`. Holds a decoded instruction until its source operands are forwardable, its destination is free, and the single register-file write port is free in its writeback slot. Issues it with a valid/ready handshake toward execute.

## Interface
- `REGS`, 64: scoreboard entries; index = {is_fpr, reg[4:0]}.
- `MAXW`, 31: largest legal `wait_time`; also the reservation-window depth minus one.
- `clk`  in  1  pipeline clock.
- `rstn`  in  1  reset: one clock; reset is asynchronous and active-low.
- `dec_valid`  in  1  decode holds an instruction.
- `rs`, `rt`  in  6  source tags {is_fpr, index}, decode encoding.
- `use_s`, `use_t`  in  1  instruction actually reads rs / rt.
- `rd`  in  5  destination index.
- `rw`  in  2  00 no write, 01 GPR, 10 FPR, 11 treated as 00.
- `wait_time`  in  5  extra cycles before the result is forwardable. Values > MAXW are clamped to MAXW.
- `ex_ready`  in  1  execute can accept this cycle.
- `issue`  out  1  instruction transferred to execute this cycle.
- `stall`  out  1  `dec_valid & ~issue`; decode/fetch hold.
- `hazard`  out  1  scoreboard/port conflict present, independent of `ex_ready`.
- `stall_count`  out  32  performance counter of stall cycles.

## Operation
- State: `cnt[REGS]` (5 bits each, 0 = available), `resv[MAXW:0]` writeback-slot reservation vector, `stall_count`.
- Dest tag `dt = {rw==2'b10, rd}`; `wr = (rw==01 || rw==10)`; `W = min(wait_time, MAXW)`.
- GPR 0 (tag 6'd0) is never busy. Writes to it load nothing and reserve no slot. Reads of it never hazard.
- RAW: `use_s && cnt[rs]!=0`, or `use_t && cnt[rt]!=0`.
- WAW: `wr && cnt[dt]!=0`.
- Port: `wr && resv[W]` (another write already owns the same writeback cycle).
- `hazard` = OR of RAW, WAW and Port, qualified by `dec_valid`.
- `issue = dec_valid & ex_ready & ~hazard`, combinational from current state and inputs.
- Per-entry update each edge:
  - if issuing write with `dt` == entry and W>0: load W;
  - else if nonzero: decrement.
  - Load beats decrement on the same entry.
- `resv <= (resv | (issue && wr ? onehot(W) : 0)) >> 1`. Bit 0 of the shifted-in side is 0.
- W==0 writes reserve slot 0 (port check) but load no countdown.
- `stall_count` increments when `stall`; saturates at 2^32-1.
- Reset: all `cnt`=0, `resv`=0, `stall_count`=0.
- No flush input: instructions already issued always complete, so their reservations remain valid.

## Timing
- Zero-latency decision: `issue`/`stall`/`hazard` valid in the same cycle as inputs.
- Reset values: `issue`=0, `stall`=0, `hazard`=0 (with `dec_valid`=0), `stall_count`=0. Asynchronous assertion clears state immediately, mid-operation included. Release is sampled at the next edge.
- Producer issued at cycle N with W:
  - `cnt[dt]`=W in cycle N+1, reaching 0 in cycle N+W+1;
  - dependent consumer first issues in N+W+1.
  - Example: LW (W=1) at N: consumer stalls 1 cycle, issues N+2.
- Back-to-back independent W=0 ops: one per cycle, no stall.
- Port slot: write issued at N with W occupies the slot checked as `resv[W-k]` at cycle N+k. A W=0 op at N+5 conflicts with a W=5 op from N.
- Simultaneous decrement-to-zero and new load of a different entry are independent.
- `ex_ready`=0: no state load, countdowns continue; `hazard` may be 0 while `stall`=1.

## Test plan
- Reset mid-run: issue W=5 FPR write to f3, assert `rstn`=0 one cycle, release -> `cnt` all 0, a reader of f3 issues first valid cycle, `stall_count`=0.
- RAW on load: LW r4 (W=1) at cycle 0, then ADD reading r4 -> `stall`=1 in cycle 1, `issue` in cycle 2, `stall_count`=1.
- FPU chain: fadd f1 (W=5) then fmul reading f1 -> 5 stall cycles, issue at cycle 6. A GPR reader of r1 in its place -> no stall.
- Port conflict: fadd f2 (W=5) at 0, independent W=0 writes at 1-4 issue, W=0 write at cycle 5 -> `hazard`=1, issues cycle 6.
- WAW and r0: fsqrt f7 (W=5) then itof to f7 -> stalls until `cnt`=0. LW r0 followed by reader of r0 -> no stall.
- Backpressure: `ex_ready`=0 for 3 cycles with no hazard -> `issue`=0, `hazard`=0, `stall_count`+=3, scoreboard countdowns still advance.

Source files
------------

// File: rtl/issue_scoreboard.sv
// Issue-stage hazard scheduler: per-register write countdowns plus a writeback-slot
// reservation window decide each cycle whether the decoded instruction may issue.
module issue_scoreboard #(
    parameter int unsigned REGS = 64,
    parameter int unsigned MAXW = 31
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        dec_valid,
    input  logic [5:0]  rs,
    input  logic [5:0]  rt,
    input  logic        use_s,
    input  logic        use_t,
    input  logic [4:0]  rd,
    input  logic [1:0]  rw,
    input  logic [4:0]  wait_time,
    input  logic        ex_ready,
    output logic        issue,
    output logic        stall,
    output logic        hazard,
    output logic [31:0] stall_count
);

    localparam int unsigned CW = 5;
    localparam int unsigned TW = 6;
    localparam int unsigned RW = MAXW + 1;
    localparam int unsigned SW = 32;

    logic [CW-1:0] cnt_q [REGS];
    logic [CW-1:0] cnt_d [REGS];
    logic [RW-1:0] resv_q, resv_d;
    logic [SW-1:0] stall_count_q, stall_count_d;

    logic [CW-1:0] w;
    logic [TW-1:0] dt;
    logic          wr;
    logic          raw;
    logic          waw;
    logic          port;

    // Decode the request; writes to GPR 0 are discarded entirely.
    always_comb begin
        w    = (TW'(wait_time) > TW'(MAXW)) ? CW'(MAXW) : wait_time;
        dt   = {rw == 2'b10, rd};
        wr   = ((rw == 2'b01) || (rw == 2'b10)) && (dt != '0);
        raw  = (use_s && (cnt_q[rs] != '0)) || (use_t && (cnt_q[rt] != '0));
        waw  = wr && (cnt_q[dt] != '0);
        port = wr && resv_q[w];
    end

    assign hazard      = dec_valid & (raw | waw | port);
    assign issue       = dec_valid & ex_ready & ~hazard;
    assign stall       = dec_valid & ~issue;
    assign stall_count = stall_count_q;

    // Countdowns load on an issuing write (load wins), otherwise run down to zero.
    always_comb begin
        for (int i = 0; i < int'(REGS); i++) begin
            cnt_d[i] = cnt_q[i];
            if (issue && wr && (dt == TW'(i)) && (w != '0)) begin
                cnt_d[i] = w;
            end else if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end
        end
        resv_d = (resv_q | ((issue && wr) ? (RW'(1) << w) : RW'(0))) >> 1;
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(REGS); i++) begin
                cnt_q[i] <= '0;
            end
            resv_q        <= '0;
            stall_count_q <= '0;
        end else begin
            for (int i = 0; i < int'(REGS); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            resv_q        <= resv_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule
